// File: rtl/trigger_seq_pkg.sv
// Shared types and helpers for the multi-stage trigger sequencer.
// Window vectors are unpacked here so the top stays free of index math.
package trigger_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STAGE,
    DONE
  } state_t;

  localparam int STAGE_W   = 2;
  localparam int SLICE_W   = 32;
  localparam int WIN_VEC_W = 3 * SLICE_W;

  function automatic logic [SLICE_W-1:0] win_slice(
    input logic [WIN_VEC_W-1:0] vec,
    input int unsigned          idx,
    input int unsigned          w
  );
    logic [WIN_VEC_W-1:0] sh;
    logic [SLICE_W-1:0]   mask;
    sh   = vec >> (idx * w);
    mask = (w >= SLICE_W) ? '1
         : ((SLICE_W'(1) << w) - SLICE_W'(1));
    return SLICE_W'(sh) & mask;
  endfunction

endpackage

// File: rtl/trigger_seq_window.sv
// Saturating inter-stage gap counter with early / in-window / timeout
// compare; gap is one more than the count, i.e. the edge distance.
module trigger_seq_window
  import trigger_seq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_adc,
  input  logic             reset,
  input  logic             clear,
  input  logic [CNT_W-1:0] min,
  input  logic [CNT_W-1:0] max,
  output logic             early,
  output logic             ok,
  output logic             timeout
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   gap;

  assign gap     = {1'b0, cnt} + (CNT_W + 1)'(1);
  assign early   = gap < {1'b0, min};
  assign timeout = (max != '0) && (gap > {1'b0, max});
  assign ok      = !early && !timeout;

  always_ff @(posedge clk_adc) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/trigger_sequencer.sv
// Ordered multi-stage trigger sequencer: each awaited stage edge must
// land inside its gap window before the capture trigger fires.
module trigger_sequencer
  import trigger_seq_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int CNT_W      = 16
) (
  input  logic                             clk_adc,
  input  logic                             reset,
  input  logic                             I_arm,
  input  logic                             I_enable,
  input  logic [1:0]                       I_num_stages,
  input  logic [NUM_STAGES-1:0]            I_trig,
  input  logic [(NUM_STAGES-1)*CNT_W-1:0]  I_window_min,
  input  logic [(NUM_STAGES-1)*CNT_W-1:0]  I_window_max,
  output logic                             O_trigger,
  output logic [1:0]                       O_stage,
  output logic [NUM_STAGES-1:0]            O_stage_active,
  output logic                             O_seq_fail,
  output logic                             O_done
);

  localparam logic [STAGE_W-1:0] TOP = STAGE_W'(NUM_STAGES - 1);

  state_t               state;
  state_t               state_nxt;
  logic [STAGE_W-1:0]   stage;
  logic [STAGE_W-1:0]   stage_nxt;
  logic [STAGE_W-1:0]   prev_idx;
  logic [STAGE_W-1:0]   last;
  logic [NUM_STAGES-1:0] trig_r;
  logic [NUM_STAGES-1:0] edges;
  logic [NUM_STAGES-1:0] act_nxt;
  logic [WIN_VEC_W-1:0] min_vec;
  logic [WIN_VEC_W-1:0] max_vec;
  logic [CNT_W-1:0]     min_cur;
  logic [CNT_W-1:0]     max_cur;
  logic                 evt;
  logic                 clear;
  logic                 early;
  logic                 ok;
  logic                 timeout;
  logic                 trig_nxt;
  logic                 fail_nxt;

  assign edges    = I_trig & ~trig_r;
  assign prev_idx = stage - STAGE_W'(1);
  assign min_vec  = WIN_VEC_W'(I_window_min);
  assign max_vec  = WIN_VEC_W'(I_window_max);
  assign min_cur  = CNT_W'(win_slice(min_vec, 32'(prev_idx), CNT_W));
  assign max_cur  = CNT_W'(win_slice(max_vec, 32'(prev_idx), CNT_W));

  // Bypass collapses the sequence to stage 0 alone.
  assign last = !I_enable ? '0
              : (I_num_stages > TOP) ? TOP
              : I_num_stages;

  always_comb begin
    evt = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (stage == STAGE_W'(k)) evt = edges[k];
    end
  end

  trigger_seq_window #(
    .CNT_W (CNT_W)
  ) u_window (
    .clk_adc (clk_adc),
    .reset   (reset),
    .clear   (clear),
    .min     (min_cur),
    .max     (max_cur),
    .early   (early),
    .ok      (ok),
    .timeout (timeout)
  );

  always_comb begin
    state_nxt = state;
    stage_nxt = stage;
    trig_nxt  = 1'b0;
    fail_nxt  = 1'b0;
    if (!I_arm) begin
      state_nxt = IDLE;
      stage_nxt = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_nxt = STAGE;
          stage_nxt = '0;
        end
        STAGE: begin
          if (stage == '0) begin
            if (evt) begin
              if (last == '0) begin
                trig_nxt  = 1'b1;
                state_nxt = DONE;
              end else begin
                stage_nxt = STAGE_W'(1);
              end
            end
          end else begin
            unique case (1'b1)
              evt && ok: begin
                if (stage >= last) begin
                  trig_nxt  = 1'b1;
                  state_nxt = DONE;
                end else begin
                  stage_nxt = stage + STAGE_W'(1);
                end
              end
              (evt && early) || timeout: begin
                fail_nxt  = 1'b1;
                stage_nxt = '0;
              end
              default: ;
            endcase
          end
        end
        DONE: ;
        default: begin
          state_nxt = IDLE;
          stage_nxt = '0;
        end
      endcase
    end
  end

  // Counter only runs while a later stage is awaited without change.
  assign clear = (state_nxt != STAGE) || (stage_nxt != stage)
              || (stage == '0);

  always_comb begin
    act_nxt = '0;
    if (state_nxt == STAGE) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        act_nxt[k] = (stage_nxt == STAGE_W'(k));
      end
    end
  end

  always_ff @(posedge clk_adc) begin
    if (reset) begin
      state          <= IDLE;
      stage          <= '0;
      trig_r         <= '0;
      O_trigger      <= 1'b0;
      O_seq_fail     <= 1'b0;
      O_done         <= 1'b0;
      O_stage_active <= '0;
    end else begin
      state          <= state_nxt;
      stage          <= stage_nxt;
      trig_r         <= I_trig;
      O_trigger      <= trig_nxt;
      O_seq_fail     <= fail_nxt;
      O_done         <= (state_nxt == DONE);
      O_stage_active <= act_nxt;
    end
  end

  assign O_stage = stage;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed plus random bench for trigger_sequencer against a
// timestamp-based reference model of the stage/gap rules.
module tb_trigger_sequencer;

  localparam int NS   = 3;
  localparam int CW   = 16;
  localparam int GMAX = 1 << CW;

  logic                 clk_adc = 1'b0;
  logic                 reset = 1'b1;
  logic                 I_arm = 1'b0;
  logic                 I_enable = 1'b0;
  logic [1:0]           I_num_stages = 2'd0;
  logic [NS-1:0]        I_trig = '0;
  logic [CW-1:0]        wmin [NS-1];
  logic [CW-1:0]        wmax [NS-1];
  logic [(NS-1)*CW-1:0] I_window_min;
  logic [(NS-1)*CW-1:0] I_window_max;
  logic                 O_trigger;
  logic [1:0]           O_stage;
  logic [NS-1:0]        O_stage_active;
  logic                 O_seq_fail;
  logic                 O_done;

  assign I_window_min = {wmin[1], wmin[0]};
  assign I_window_max = {wmax[1], wmax[0]};

  trigger_sequencer #(
    .NUM_STAGES (NS),
    .CNT_W      (CW)
  ) dut (
    .clk_adc        (clk_adc),
    .reset          (reset),
    .I_arm          (I_arm),
    .I_enable       (I_enable),
    .I_num_stages   (I_num_stages),
    .I_trig         (I_trig),
    .I_window_min   (I_window_min),
    .I_window_max   (I_window_max),
    .O_trigger      (O_trigger),
    .O_stage        (O_stage),
    .O_stage_active (O_stage_active),
    .O_seq_fail     (O_seq_fail),
    .O_done         (O_done)
  );

  always #5 clk_adc = ~clk_adc;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int cyc    = 0;

  // Model: 0 idle, 1 sequencing, 2 done; m_last is the cycle of the
  // previous accepted event, so gap is a plain cycle difference.
  int            m_st = 0;
  int            m_stage = 0;
  int            m_last = 0;
  bit            m_trig = 0;
  bit            m_fail = 0;
  logic [NS-1:0] m_prev = '0;

  task automatic model_step();
    logic [NS-1:0] e;
    int used, gap, mn, mx;
    e = I_trig & ~m_prev;
    cyc++;
    m_trig = 0;
    m_fail = 0;
    used = !I_enable ? 0 : (int'(I_num_stages) > NS - 1 ? NS - 1
                            : int'(I_num_stages));
    if (reset) begin
      m_st = 0;
      m_stage = 0;
      m_prev = '0;
    end else begin
      m_prev = I_trig;
      if (!I_arm) begin
        m_st = 0;
        m_stage = 0;
      end else if (m_st == 0) begin
        m_st = 1;
        m_stage = 0;
      end else if (m_st == 1) begin
        if (m_stage == 0) begin
          if (e[0]) begin
            if (used == 0) begin
              m_trig = 1;
              m_st = 2;
            end else begin
              m_stage = 1;
              m_last = cyc;
            end
          end
        end else begin
          gap = cyc - m_last;
          if (gap > GMAX) gap = GMAX;
          mn = int'(wmin[m_stage-1]);
          mx = int'(wmax[m_stage-1]);
          if (e[m_stage] && gap >= mn && (mx == 0 || gap <= mx)) begin
            if (m_stage >= used) begin
              m_trig = 1;
              m_st = 2;
            end else begin
              m_stage++;
              m_last = cyc;
            end
          end else if ((e[m_stage] && gap < mn) || (mx != 0 && gap > mx)) begin
            m_fail = 1;
            m_stage = 0;
          end
        end
      end
    end
  endtask

  function automatic logic [7:0] exp_vec();
    logic [2:0] act;
    act = (m_st == 1) ? 3'(1 << m_stage) : 3'b000;
    return {m_trig, m_fail, (m_st == 2), 2'(m_stage), act};
  endfunction

  function automatic logic [7:0] got_vec();
    return {O_trigger, O_seq_fail, O_done, O_stage, O_stage_active};
  endfunction

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick(input bit check = 1'b1);
    @(posedge clk_adc);
    model_step();
    #1;
    if (check) chk("tick", got_vec(), exp_vec());
  endtask

  task automatic wait_gap(input int g, input int k);
    I_trig = '0;
    repeat (g - 1) tick();
    I_trig[k] = 1'b1;
    tick();
  endtask

  task automatic arm();
    I_arm = 1'b1;
    tick();
  endtask

  task automatic disarm();
    I_arm = 1'b0;
    I_trig = '0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < NS - 1; i++) begin
      wmin[i] = '0;
      wmax[i] = '0;
    end
    tick();
    tick();
    chk("reset", got_vec(), 8'h00);
    reset = 1'b0;

    // bypass: stage 0 alone fires the trigger
    I_enable = 1'b0;
    arm();
    repeat (8) tick();
    I_trig[0] = 1'b1;
    tick();
    chk("bypass_trig", 8'({O_trigger, O_done}), 8'b11);
    I_trig = '0;
    tick();
    chk("bypass_held", 8'({O_trigger, O_done}), 8'b01);
    disarm();
    chk("disarm", got_vec(), 8'h00);

    // two stages inside the window
    I_enable = 1'b1;
    I_num_stages = 2'd1;
    wmin[0] = 16'd5;
    wmax[0] = 16'd20;
    arm();
    wait_gap(3, 0);
    chk("s2_stage1", 8'({O_stage, O_stage_active}), 8'({2'd1, 3'b010}));
    wait_gap(10, 1);
    chk("s2_trig", 8'({O_trigger, O_done, O_stage}), 8'({2'b11, 2'd1}));
    tick();
    chk("s2_held", 8'({O_trigger, O_done, O_stage}), 8'({2'b01, 2'd1}));
    disarm();

    // early edge, then a clean sequence
    arm();
    wait_gap(2, 0);
    wait_gap(3, 1);
    chk("early", 8'({O_seq_fail, O_trigger, O_stage}), 8'({2'b10, 2'd0}));
    wait_gap(2, 0);
    wait_gap(7, 1);
    chk("recover", 8'(O_trigger), 8'd1);
    disarm();

    // timeout with no stage-1 edge
    wmax[0] = 16'd8;
    arm();
    wait_gap(2, 0);
    I_trig = '0;
    repeat (8) tick();
    chk("to_wait", 8'({O_seq_fail, O_stage_active}), 8'({1'b0, 3'b010}));
    tick();
    chk("timeout", 8'({O_seq_fail, O_stage, O_stage_active}),
        8'({1'b1, 2'd0, 3'b001}));
    disarm();

    // window boundaries
    wmax[0] = 16'd20;
    arm();
    wait_gap(2, 0);
    wait_gap(5, 1);
    chk("gap5", 8'({O_trigger, O_seq_fail}), 8'b10);
    disarm();
    arm();
    wait_gap(2, 0);
    wait_gap(20, 1);
    chk("gap20", 8'({O_trigger, O_seq_fail}), 8'b10);
    disarm();
    arm();
    wait_gap(2, 0);
    wait_gap(21, 1);
    chk("gap21", 8'({O_trigger, O_seq_fail}), 8'b01);
    disarm();

    // three stages: abort by arm, stale edge, full run, abort by reset
    I_num_stages = 2'd2;
    wmin[0] = 16'd3;
    wmax[0] = 16'd0;
    wmin[1] = 16'd2;
    wmax[1] = 16'd10;
    arm();
    wait_gap(2, 0);
    wait_gap(4, 1);
    chk("s3_stage2", 8'({O_stage, O_stage_active}), 8'({2'd2, 3'b100}));
    I_arm = 1'b0;
    tick();
    chk("abort_arm", got_vec(), 8'h00);
    arm();
    I_trig[2] = 1'b1;
    tick();
    chk("stale_edge", got_vec(), 8'({3'b000, 2'd0, 3'b001}));
    wait_gap(2, 0);
    wait_gap(4, 1);
    wait_gap(5, 2);
    chk("s3_trig", 8'({O_trigger, O_done}), 8'b11);
    disarm();
    arm();
    wait_gap(2, 0);
    wait_gap(4, 1);
    reset = 1'b1;
    tick();
    chk("abort_rst", got_vec(), 8'h00);
    reset = 1'b0;
    tick();
    I_trig = '0;
    I_trig[2] = 1'b1;
    tick();
    chk("rst_stale", got_vec(), 8'({3'b000, 2'd0, 3'b001}));
    disarm();

    // unbounded window across counter saturation
    I_num_stages = 2'd1;
    wmin[0] = 16'hFFFF;
    wmax[0] = 16'd0;
    arm();
    wait_gap(2, 0);
    I_trig = '0;
    for (int i = 0; i < 65999; i++) tick((i % 1000) == 0);
    I_trig[1] = 1'b1;
    tick();
    chk("sat_accept", 8'({O_trigger, O_seq_fail}), 8'b10);
    disarm();

    // random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        if (!I_arm) begin
          I_enable = ($urandom_range(0, 4) != 0);
          I_num_stages = 2'($urandom_range(0, 3));
          for (int s = 0; s < NS - 1; s++) begin
            wmin[s] = 16'($urandom_range(0, 6));
            wmax[s] = ($urandom_range(0, 3) == 0) ? 16'd0
                    : 16'($urandom_range(1, 14));
          end
        end
        I_arm = ~I_arm;
      end
      if ($urandom_range(0, 199) == 0) reset = 1'b1;
      for (int b = 0; b < NS; b++) begin
        if ($urandom_range(0, 3) == 0) I_trig[b] = ~I_trig[b];
      end
      tick();
      reset = 1'b0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/trigger_sequencer.md
# trigger_sequencer

Sequences up to `NUM_STAGES` trigger sources so that a capture trigger fires only after each stage's trigger occurs in order, with each inter-stage gap inside a programmable cycle window. It sits between the per-stage trigger choosers and the capture/arm logic. It drives the one-hot `O_stage_active` vector that enables whichever trigger module is currently awaited. It emits a single-cycle `O_trigger` when the final stage fires.

## Interface
Parameters:
- `NUM_STAGES`, 2: number of hardware stages, range 2–4.
- `CNT_W`, 16: width of the gap counter and window bounds.

Ports:
- `clk_adc`  in  1: sole clock.
- `reset`  in  1: synchronous, active-high reset.
- `I_arm`  in  1: level; sequence runs only while high.
- `I_enable`  in  1: 0 = bypass (stage 0 only, no windows).
- `I_num_stages`  in  2: stages used minus 1; values above `NUM_STAGES-1` are clamped to `NUM_STAGES-1`.
- `I_trig`  in  `NUM_STAGES`: per-stage trigger levels from the trigger choosers.
- `I_window_min`  in  `(NUM_STAGES-1)*CNT_W`: slice k-1 is the minimum gap into stage k.
- `I_window_max`  in  `(NUM_STAGES-1)*CNT_W`: slice k-1 is the maximum gap into stage k; 0 = unbounded.
- `O_trigger`  out  1: one-cycle pulse when the final stage fires.
- `O_stage`  out  2: index of the currently awaited stage.
- `O_stage_active`  out  `NUM_STAGES`: one-hot enable for the awaited stage's trigger module; all zero outside `STAGE`.
- `O_seq_fail`  out  1: one-cycle pulse on an early edge or a timeout.
- `O_done`  out  1: high from the final trigger until `I_arm` falls.

## Operation
- Edge detection: `trig_r <= I_trig` every cycle. A stage event is `I_trig[k] & ~trig_r[k]`. Only the awaited stage's edge is evaluated; edges on all other inputs are ignored.
- States: `IDLE`, `STAGE`, `DONE`.
- `IDLE`: stage = 0 and cnt = 0. On `I_arm` = 1, go to `STAGE`.
- `STAGE` with stage = 0: an edge advances stage to 1 and clears cnt to 0. If the used stage count is 1 (`I_num_stages` = 0, or `I_enable` = 0), the edge instead pulses `O_trigger` and goes to `DONE`.
- `STAGE` with stage = k ≥ 1: cnt increments every cycle and saturates at 2^CNT_W−1. Define gap = cnt+1 in the cycle an edge is seen, i.e. the cycle distance from the previous stage event.
  - Edge with gap < min[k-1]: early. Pulse `O_seq_fail`, set stage to 0. The edge is discarded and not counted as a stage-0 event.
  - Edge with min ≤ gap and (max = 0 or gap ≤ max): accepted. If k is the last used stage, pulse `O_trigger` and go to `DONE`. Otherwise set stage to k+1 and clear cnt.
  - No edge, max ≠ 0 and cnt+1 == max: timeout. On the next edge (gap = max+1), pulse `O_seq_fail` and set stage to 0.
- An accepted edge that coincides with the timeout boundary wins over the timeout.
- `DONE`: `O_done` = 1; all edges are ignored. When `I_arm` = 0, go to `IDLE`.
- `I_arm` = 0 in any state: go to `IDLE` on the next edge, without a fail pulse.
- Window inputs and `I_num_stages` are sampled live. Software changes them only while disarmed.

## Timing
- Reset values: state `IDLE`; `O_trigger`, `O_seq_fail`, `O_done` = 0; `O_stage` = 0; `O_stage_active` = 0; cnt = 0; `trig_r` = 0.
- All outputs are registered.
- `O_trigger` latency: 1 cycle. An input rise sampled at edge t produces `O_trigger` high during cycle t+1, for exactly one cycle.
- `O_stage` and `O_stage_active` update on the same edge as the transition.
- Reset mid-sequence: returns to `IDLE` on the next edge; no pulses are emitted.

## Structure
- Package `trigger_seq_pkg`: state enum (`IDLE`, `STAGE`, `DONE`), `STAGE_W` = 2, and a slice-extraction function for the packed window vectors.
- One sub-module, `trigger_seq_window`: saturating gap counter plus early / in-window / timeout compare. Inputs are clear, min and max; outputs are `early`, `ok` and `timeout`.

## Test plan
- Bypass: `I_enable`=0, arm, raise `I_trig[0]` at cycle 10 → `O_trigger` high only in cycle 11; `O_done`=1 from cycle 11.
- 2-stage in window: min=5, max=20; `I_trig[0]` rises at 100 and `I_trig[1]` at 110 → `O_trigger` in cycle 111; `O_stage` reads 0, then 1, then held.
- Early: min=5, `I_trig[1]` rises 3 cycles after stage 0 → `O_seq_fail` pulse, `O_stage`=0, no trigger. A later valid sequence then triggers normally.
- Timeout: max=8, no `I_trig[1]` → `O_seq_fail` 9 cycles after the stage-0 edge; `O_stage_active`=01.
- Boundaries: gap exactly 5 and exactly 20 (min=5, max=20) → accepted. Gap 21 → fail. Max=0 with gap 60000 → accepted. Saturation at 65535 → no wrap.
- Abort: drop `I_arm`, or assert `reset`, while in stage 2 of 3 → `IDLE` next cycle with all outputs 0. The stale `I_trig[2]` edge is ignored.
